sum_window_acc: RTL and testbench

SUM_WINDOW_ACC -- requirements
Module: sum_window_acc

---
 rtl/sum_window_acc_pkg.sv | 14 +
 rtl/sum_window_acc_if.sv | 27 ++
 rtl/sum_window_acc_add.sv | 23 ++
 rtl/sum_window_acc.sv | 100 ++++++++++
 tb/tb_sum_window_acc.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/sum_window_acc_pkg.sv
// Shared types and default widths for the windowed sum accumulator.
package sum_window_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ACC_W  = 20;
    localparam int DEFAULT_CNT_W  = 8;

endpackage

// File: rtl/sum_window_acc_if.sv
// Sample input and result output handshakes of the windowed sum accumulator.
interface sum_window_acc_if
    import sum_window_acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int CNT_W  = DEFAULT_CNT_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_cnt, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sum, out_cnt, out_ovf, out_valid
    );
endinterface

// File: rtl/sum_window_acc_add.sv
// Combinational accumulator adder with carry out.
// Defining SUM_WINDOW_ACC_SAT_EN clamps the sum to all-ones on carry instead of wrapping.
module sum_window_acc_add #(
    parameter int ACC_W  = 20,
    parameter int DATA_W = 16
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] raw;

    always_comb begin
        raw   = {1'b0, a} + {{(ACC_W-DATA_W+1){1'b0}}, b};
        carry = raw[ACC_W];
`ifdef SUM_WINDOW_ACC_SAT_EN
        sum   = carry ? '1 : raw[ACC_W-1:0];
`else
        sum   = raw[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/sum_window_acc.sv
// Sums a window of win_len samples (or until flush) and holds the result until consumed.
// Overflow handling is chosen by SUM_WINDOW_ACC_SAT_EN (see sum_window_acc_add).
module sum_window_acc
    import sum_window_acc_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [CNT_W-1:0] win_len,
    input  logic             flush,
    sum_window_acc_if.slave  bus
);
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    sum_window_acc_add #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_add (
        .a     (acc_q),
        .b     (bus.in_data),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Handshake outputs decode the state register only, keeping in_valid/out_ready off any output path.
    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

    assign accept  = bus.in_valid && (state_q != HOLD);
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = (win_len == '0) ? CNT_W'(1) : win_len;
                    acc_d   = {{(ACC_W-DATA_W){1'b0}}, bus.in_data};
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (len_d == CNT_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | add_carry;
                    if (flush || (cnt_inc == len_q)) begin
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= CNT_W'(1);
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_sum_window_acc.sv
// Directed self-checking bench for sum_window_acc; honours SUM_WINDOW_ACC_SAT_EN for the overflow case.
module tb_sum_window_acc;
    import sum_window_acc_pkg::*;

    logic       clock;
    logic       rst;
    logic [7:0] win_len;
    logic       flush;
    int         vectors;
    int         miscompares;
    logic [31:0] ovf_sum_exp;

    sum_window_acc_if #(.DATA_W(16), .ACC_W(20), .CNT_W(8)) bus ();

    sum_window_acc #(.DATA_W(16), .ACC_W(20), .CNT_W(8)) dut (
        .clock   (clock),
        .rst     (rst),
        .win_len (win_len),
        .flush   (flush),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; checks happen in that same settled window.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [31:0] sum, input logic [31:0] cnt,
                               input logic [31:0] ovf, input logic [31:0] valid);
        checkOutput({tag, ".sum"},   32'(bus.out_sum),   sum);
        checkOutput({tag, ".cnt"},   32'(bus.out_cnt),   cnt);
        checkOutput({tag, ".ovf"},   32'(bus.out_ovf),   ovf);
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), valid);
    endtask

    task automatic applyStimulus(input logic [15:0] data);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        win_len      = 8'd1;
        flush        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
`ifdef SUM_WINDOW_ACC_SAT_EN
        ovf_sum_exp = 32'hFFFFF;
`else
        ovf_sum_exp = 32'hFFFE0;
`endif
        tick();
        tick();
        rst = 1'b0;
        checkResult("reset", 0, 0, 0, 0);
        checkOutput("reset.in_ready", 32'(bus.in_ready), 1);

        // Four back-to-back samples, result consumed immediately
        win_len = 8'd4;
        applyStimulus(16'd10);
        applyStimulus(16'd20);
        applyStimulus(16'd30);
        applyStimulus(16'd40);
        checkResult("w4", 100, 4, 0, 1);
        checkOutput("w4.in_ready", 32'(bus.in_ready), 0);
        tick();
        checkOutput("w4.single_valid", 32'(bus.out_valid), 0);

        // Flush alone closes a partial window
        win_len = 8'd8;
        applyStimulus(16'd5);
        applyStimulus(16'd5);
        applyStimulus(16'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkResult("flush_only", 15, 3, 0, 1);
        tick();

        // Flush together with a sample includes that sample
        applyStimulus(16'd5);
        applyStimulus(16'd5);
        applyStimulus(16'd5);
        flush = 1'b1;
        applyStimulus(16'd5);
        flush = 1'b0;
        checkResult("flush_acc", 20, 4, 0, 1);
        tick();

        // 32 x 0xFFFF overflows 20 bits
        win_len = 8'd32;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(16'hFFFF);
        end
        checkResult("ovf", ovf_sum_exp, 32, 1, 1);
        tick();
        checkOutput("ovf.cleared", 32'(bus.out_ovf), 0);

        // Result held under backpressure; win_len change mid-window ignored
        bus.out_ready = 1'b0;
        win_len = 8'd2;
        applyStimulus(16'd3);
        win_len = 8'd5;
        applyStimulus(16'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd99;
        for (int i = 0; i < 5; i++) begin
            checkResult("hold", 7, 2, 0, 1);
            checkOutput("hold.in_ready", 32'(bus.in_ready), 0);
            tick();
        end
        win_len = 8'd1;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("release.in_ready", 32'(bus.in_ready), 1);
        checkOutput("release.valid", 32'(bus.out_valid), 0);
        tick();
        bus.in_valid = 1'b0;
        checkResult("after_hold", 99, 1, 0, 1);
        tick();

        // Reset mid-window discards the partial sum
        win_len = 8'd4;
        applyStimulus(16'd1);
        applyStimulus(16'd2);
        rst   = 1'b1;
        flush = 1'b1;
        applyStimulus(16'd3);
        rst   = 1'b0;
        flush = 1'b0;
        checkResult("rst_mid", 0, 0, 0, 0);
        checkOutput("rst_mid.in_ready", 32'(bus.in_ready), 1);
        win_len = 8'd1;
        applyStimulus(16'd7);
        checkResult("post_rst", 7, 1, 0, 1);
        tick();

        // Flush in IDLE does nothing
        flush = 1'b1;
        tick();
        checkOutput("idle_flush.valid", 32'(bus.out_valid), 0);
        flush = 1'b0;

        // win_len of zero behaves as one; flush ignored in HOLD
        win_len = 8'd0;
        bus.out_ready = 1'b0;
        applyStimulus(16'd9);
        checkResult("len0", 9, 1, 0, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkResult("hold_flush", 9, 1, 0, 1);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("len0.done", 32'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
